booth_mul_r4: RTL and testbench

BOOTH_MUL_R4 -- requirements
Module: booth_mul_r4

---
 rtl/booth_mul_r4.sv | 110 +++++++++++
 tb/tb_booth_mul_r4.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth multiplier: signed or unsigned WIDTH x WIDTH -> 2*WIDTH product.
// It retires one Booth digit per clock and takes a fixed WIDTH/2+1 cycles per operation.
module booth_mul_r4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / 2 + 1;
  localparam int CW    = $clog2(STEPS);
  localparam int MW    = WIDTH + 3;
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [MW-1:0]   r_mplier;
  logic [PW-1:0]   r_mcand;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_product;
  logic [CW-1:0]   r_cnt;

  logic            w_ext;
  logic [PW-1:0]   w_mcand_ext;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_acc_next;
  logic            w_last;
  logic            w_accept;

  assign w_ext       = is_signed & multiplier[WIDTH-1];
  assign w_mcand_ext = is_signed ? {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand}
                                 : {{WIDTH{1'b0}}, multiplicand};
  assign w_last      = (r_cnt == CW'(STEPS - 1));
  assign w_accept    = start && (r_state != S_RUN);

  // r_mcand is pre-shifted by 2k each step, so the digit only picks 0, +-A or +-2A.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_addend = '0;
    case (r_mplier[2:0])
      3'b001, 3'b010: w_addend = r_mcand;
      3'b011:         w_addend = r_mcand << 1;
      3'b100:         w_addend = -(r_mcand << 1);
      3'b101, 3'b110: w_addend = -r_mcand;
      default:        w_addend = '0;
    endcase
  end

  assign w_acc_next = r_acc + w_addend;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mplier <= {w_ext, w_ext, multiplier, 1'b0};
      r_mcand  <= w_mcand_ext;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_next;
      r_mplier <= {{2{r_mplier[MW-1]}}, r_mplier[MW-1:2]};
      r_mcand  <= r_mcand << 2;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_product <= w_acc_next;
    end
  end

  assign product_lo = r_product[WIDTH-1:0];
  assign product_hi = r_product[PW-1:WIDTH];
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_booth_mul_r4.sv
// Self-checking bench for booth_mul_r4 (WIDTH=32): directed corner cases plus random operands
// compared against a plain 64-bit arithmetic reference product.
module tb_booth_mul_r4;

  localparam int W     = 32;
  localparam int LAT   = W / 2 + 1;
  localparam int LIMIT = 60;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic [W-1:0] product_lo;
  logic [W-1:0] product_hi;
  logic         busy;
  logic         done;

  int             n_checks = 0;
  int             n_pass   = 0;
  logic [2*W-1:0] last_exp;
  logic [W-1:0]   corners [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'h7FFF_FFFF};

  booth_mul_r4 #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product_lo   (product_lo),
    .product_hi   (product_hi),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic sg, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [W-1:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic start_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; is_signed = sg; multiplicand = a; multiplier = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc counts negedges since the start edge; optional mid-run start (inj) or reset (rst) pulse.
  task automatic wait_done(input int inj, input int rst, output int cyc, output int busy_cnt,
                           output logic [2*W+1:0] snap);
    cyc = 0; busy_cnt = 0; snap = '0;
    while (!done && cyc < LIMIT) begin
      if (busy) busy_cnt++;
      if (rst >= 0 && cyc == rst + 1) snap = {busy, done, product_hi, product_lo};
      start = (cyc == inj);
      if (cyc == inj) begin
        is_signed = 1'b0; multiplicand = 32'd9; multiplier = 32'd9;
      end
      reset = (cyc == rst);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int               cyc, bc;
    logic [2*W+1:0]   snap;
    logic [2*W-1:0]   exp;
    exp = ref_mul(sg, a, b);
    start_op(sg, a, b);
    check($sformatf("%s/busy", tag), 64'(busy), 64'd1);
    check($sformatf("%s/hold", tag), {product_hi, product_lo}, last_exp);
    wait_done(-1, -1, cyc, bc, snap);
    check($sformatf("%s/lat", tag), 64'(cyc), 64'(LAT));
    check($sformatf("%s/busy_cycles", tag), 64'(bc), 64'(LAT));
    check($sformatf("%s/busy_at_done", tag), 64'(busy), 64'd0);
    check($sformatf("%s/prod", tag), {product_hi, product_lo}, exp);
    last_exp = exp;
  endtask

  initial begin
    int             cyc, bc;
    logic [2*W+1:0] snap;
    logic           sg;

    reset = 1'b1; start = 1'b1; is_signed = 1'b0;
    multiplicand = 32'd5; multiplier = 32'd7;
    repeat (3) @(negedge clk);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/prod", {product_hi, product_lo}, 64'd0);
    reset = 1'b0; start = 1'b0;
    last_exp = '0;

    run_op(1'b0, 32'd7, 32'd6, "u7x6");
    check("u7x6/const", {product_hi, product_lo}, 64'h0000_0000_0000_002A);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);

    run_op(1'b1, 32'hFFFF_FFFD, 32'd5, "s_m3x5");
    check("s_m3x5/const", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(1'b0, 32'hFFFF_FFFD, 32'd5, "u_m3x5");
    check("u_m3x5/const", {product_hi, product_lo}, 64'h0000_0004_FFFF_FFF1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "u_ones");
    check("u_ones/const", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "s_ones");
    check("s_ones/const", {product_hi, product_lo}, 64'h0000_0000_0000_0001);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "s_minneg");
    check("s_minneg/const", {product_hi, product_lo}, 64'h4000_0000_0000_0000);

    // A start during RUN is ignored; a start in the DONE cycle chains with no idle gap.
    @(negedge clk);
    start_op(1'b0, 32'd3, 32'd4);
    wait_done(4, -1, cyc, bc, snap);
    check("ign/lat", 64'(cyc), 64'(LAT));
    check("ign/prod", {product_hi, product_lo}, 64'd12);
    start_op(1'b0, 32'd9, 32'd9);
    check("b2b/busy", 64'(busy), 64'd1);
    check("b2b/done", 64'(done), 64'd0);
    check("b2b/hold", {product_hi, product_lo}, 64'd12);
    wait_done(-1, -1, cyc, bc, snap);
    check("b2b/lat", 64'(cyc), 64'(LAT));
    check("b2b/prod", {product_hi, product_lo}, 64'd81);
    last_exp = 64'd81;

    // Reset in the middle of RUN aborts without a done pulse and clears the product.
    @(negedge clk);
    start_op(1'b0, 32'h0001_2345, 32'h0006_789A);
    wait_done(-1, 7, cyc, bc, snap);
    check("abort/outputs", 64'(snap), 64'd0);
    check("abort/no_done", 64'(cyc), 64'(LIMIT));
    check("abort/busy_cycles", 64'(bc), 64'd8);
    check("abort/prod", {product_hi, product_lo}, 64'd0);
    last_exp = '0;
    run_op(1'b0, 32'd2, 32'd3, "post_rst");
    check("post_rst/const", {product_hi, product_lo}, 64'd6);

    for (int i = 0; i < 40; i++) begin
      sg = 1'(($urandom_range(0, 1)));
      run_op(sg, pick(), pick(), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check($sformatf("rnd%0d/done_pulse", i), 64'(done), 64'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
